calc_sequencer: RTL and testbench
=================================

CALC_SEQUENCER -- requirements
Module: calc_sequencer

Interface
REQ-001 Parameter NUM_INPUTS, 784, number of pixel/weight products accumulated per output neuron.
REQ-002 Parameter NUM_OUTPUTS, 10, number of output neurons; each neuron is one result slot.
REQ-003 Parameter DRAIN_CYCLES, 2, idle cycles after the last fetch before a result is stored; legal range 1..7.
REQ-004 clk  input  1  clock; all state updates on the rising edge.
REQ-005 n_rst  input  1  reset, asynchronous, active-low.
REQ-006 start_calc  input  1  level request from the CSR start bit; high = run, low = abort or acknowledge.
REQ-007 pixel_read_address  output  11  pixel RAM read address.
REQ-008 weight_read_address  output  13  weight RAM read address.
REQ-009 mem_read  output  1  read strobe to both RAMs, 1-cycle read latency.
REQ-010 mac_clear  output  1  synchronous clear of the external accumulator.
REQ-011 mac_enable  output  1  accumulate pixel*weight from RAM read data this cycle.
REQ-012 result_write  output  1  store the accumulator into the result slot.
REQ-013 result_address  output  4  result slot index, 0..NUM_OUTPUTS-1.
REQ-014 busy  output  1  high in every state except IDLE and DONE.
REQ-015 done_calc  output  1  high only in state DONE.

Function
REQ-016 The FSM SHALL have states IDLE, CLEAR, FETCH, DRAIN, STORE and DONE, all registered.
REQ-017 IDLE: all outputs 0; start_calc=1 -> CLEAR, with in_cnt, out_cnt and weight_cnt zeroed.
REQ-018 CLEAR: mac_clear=1 for exactly one cycle, in_cnt=0 -> FETCH.
REQ-019 FETCH: mem_read=1, pixel_read_address=in_cnt, weight_read_address=weight_cnt; in_cnt and weight_cnt increment each cycle; -> DRAIN in the cycle in_cnt==NUM_INPUTS-1.
REQ-020 weight_cnt SHALL be a running counter equal to out_cnt*NUM_INPUTS+in_cnt; no multiplier.
REQ-021 mac_enable SHALL be mem_read delayed by one register stage, so it is high NUM_INPUTS consecutive cycles per neuron, the last one in the first DRAIN cycle.
REQ-022 DRAIN: hold for exactly DRAIN_CYCLES cycles using a drain counter -> STORE.
REQ-023 STORE: result_write=1 and result_address=out_cnt for one cycle; out_cnt==NUM_OUTPUTS-1 -> DONE, else out_cnt increments -> CLEAR.
REQ-024 DONE: done_calc=1 held; start_calc=0 -> IDLE; start_calc held high SHALL NOT retrigger a run.
REQ-025 Abort: start_calc=0 in CLEAR, FETCH, DRAIN or STORE -> IDLE next cycle; no result_write issued; mac_enable pipeline register cleared; done_calc stays 0.
REQ-026 result_address and pixel_read_address SHALL be 0 whenever their strobe is low.
REQ-027 Latency: with start_calc sampled high at edge 0, done_calc first rises in cycle NUM_OUTPUTS*(NUM_INPUTS+DRAIN_CYCLES+2)+1 (7881 with default parameters).
REQ-028 Counters SHALL never wrap: in_cnt stops at NUM_INPUTS-1 and out_cnt at NUM_OUTPUTS-1.

Reset
REQ-029 n_rst low SHALL force state IDLE, all counters and the mac_enable pipeline register to 0, and every output to 0, asynchronously, including mid-run.
REQ-030 After reset release, a run SHALL start only once start_calc is sampled high in IDLE.

Structure
REQ-031 The state enum, parameter defaults and address widths (11, 13, 4) SHALL live in a shared package nn_pkg.
REQ-032 in_cnt and the drain counter SHALL use one sub-module, calc_counter: a clear/enable counter with a programmable terminal count and a terminal flag.
REQ-033 The block SHALL contain no arithmetic datapath; multiply/accumulate stays in the external MAC.

Verification (NUM_INPUTS=4, NUM_OUTPUTS=2, DRAIN_CYCLES=2 unless noted)
REQ-034 start_calc high at edge 0 -> CLEAR cycles 1 and 9; FETCH 2-5 and 10-13; weight addresses 0..3 then 4..7; mac_enable high 3-6 and 11-14; result_write at cycles 8 (addr 0) and 16 (addr 1); done_calc from cycle 17.
REQ-035 start_calc held high 20 cycles past DONE -> done_calc stays 1, no further mem_read; start_calc low -> IDLE next cycle, done_calc 0.
REQ-036 start_calc dropped in cycle 4 (FETCH) -> IDLE at cycle 5, mac_enable 0 from cycle 5, no result_write, done_calc never asserted.
REQ-037 n_rst pulsed low in cycle 12 -> all outputs 0 immediately; restart gives weight address sequence starting at 0 again.
REQ-038 Default parameters, full run -> last weight_read_address 7839, exactly 10 result_write pulses at addresses 0..9, done_calc first high in cycle 7881.

Source files
------------

// File: rtl/nn_pkg.sv
// Shared definitions for the neural-network calculation block: the sequencer
// state encoding, default sizing parameters and the RAM/result address widths.
package nn_pkg;

    localparam int DEFAULT_NUM_INPUTS   = 784;
    localparam int DEFAULT_NUM_OUTPUTS  = 10;
    localparam int DEFAULT_DRAIN_CYCLES = 2;

    localparam int PIXEL_ADDR_W  = 11;
    localparam int WEIGHT_ADDR_W = 13;
    localparam int RESULT_ADDR_W = 4;
    localparam int DRAIN_CNT_W   = 3;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        FETCH = 3'd2,
        DRAIN = 3'd3,
        STORE = 3'd4,
        DONE  = 3'd5
    } calc_state_t;

endpackage

// File: rtl/calc_counter.sv
// Saturating up-counter with synchronous clear, count enable and a
// programmable terminal count. The terminal flag is high while the count
// equals the terminal value, and the count holds there instead of wrapping.
module calc_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             clear,
    input  logic             enable,
    input  logic [WIDTH-1:0] terminal_count,
    output logic [WIDTH-1:0] count,
    output logic             terminal
);

    assign terminal = (count == terminal_count);

    // Count up while enabled; clear wins over enable; hold once terminal.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !terminal) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/calc_sequencer.sv
// Sequencer for a fully connected layer: for each output neuron it clears the
// external MAC, streams NUM_INPUTS pixel/weight pairs out of the RAMs, waits for
// the MAC pipeline to drain, then stores the accumulator into a result slot.
// Dropping start_calc at any point while busy aborts back to IDLE.
module calc_sequencer
    import nn_pkg::*;
#(
    parameter int NUM_INPUTS   = DEFAULT_NUM_INPUTS,
    parameter int NUM_OUTPUTS  = DEFAULT_NUM_OUTPUTS,
    parameter int DRAIN_CYCLES = DEFAULT_DRAIN_CYCLES
) (
    input  logic                     clk,
    input  logic                     n_rst,
    input  logic                     start_calc,
    output logic [PIXEL_ADDR_W-1:0]  pixel_read_address,
    output logic [WEIGHT_ADDR_W-1:0] weight_read_address,
    output logic                     mem_read,
    output logic                     mac_clear,
    output logic                     mac_enable,
    output logic                     result_write,
    output logic [RESULT_ADDR_W-1:0] result_address,
    output logic                     busy,
    output logic                     done_calc
);

    localparam logic [PIXEL_ADDR_W-1:0]  IN_LAST    = PIXEL_ADDR_W'(NUM_INPUTS - 1);
    localparam logic [RESULT_ADDR_W-1:0] OUT_LAST   = RESULT_ADDR_W'(NUM_OUTPUTS - 1);
    localparam logic [DRAIN_CNT_W-1:0]   DRAIN_LAST = DRAIN_CNT_W'(DRAIN_CYCLES - 1);

    calc_state_t              state;
    calc_state_t              next_state;
    logic [PIXEL_ADDR_W-1:0]  in_cnt;
    logic                     in_last;
    logic [DRAIN_CNT_W-1:0]   drain_cnt;
    logic                     drain_last;
    logic [RESULT_ADDR_W-1:0] out_cnt;
    logic [WEIGHT_ADDR_W-1:0] weight_cnt;
    logic                     mac_pipe;

    // Input index within the current neuron; only counts during FETCH.
    calc_counter #(
        .WIDTH(PIXEL_ADDR_W)
    ) u_in_counter (
        .clk           (clk),
        .n_rst         (n_rst),
        .clear         (state != FETCH),
        .enable        (state == FETCH),
        .terminal_count(IN_LAST),
        .count         (in_cnt),
        .terminal      (in_last)
    );

    // Drain wait so the last RAM read has passed through the MAC before STORE.
    calc_counter #(
        .WIDTH(DRAIN_CNT_W)
    ) u_drain_counter (
        .clk           (clk),
        .n_rst         (n_rst),
        .clear         (state != DRAIN),
        .enable        (state == DRAIN),
        .terminal_count(DRAIN_LAST),
        .count         (drain_cnt),
        .terminal      (drain_last)
    );

    // State register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Output neuron index: zeroed in IDLE, advanced after each completed store.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            out_cnt <= '0;
        end else if (state == IDLE) begin
            out_cnt <= '0;
        end else if (state == STORE && start_calc && out_cnt != OUT_LAST) begin
            out_cnt <= out_cnt + RESULT_ADDR_W'(1);
        end
    end

    // Running weight address; stepping it every FETCH cycle keeps it equal to
    // out_cnt*NUM_INPUTS+in_cnt without a multiplier.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            weight_cnt <= '0;
        end else if (state == IDLE) begin
            weight_cnt <= '0;
        end else if (state == FETCH && start_calc) begin
            weight_cnt <= weight_cnt + WEIGHT_ADDR_W'(1);
        end
    end

    // RAM read data arrives one cycle after mem_read; an abort flushes it.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            mac_pipe <= 1'b0;
        end else begin
            mac_pipe <= mem_read && start_calc;
        end
    end

    assign mac_enable = mac_pipe;

    // Next-state and Moore outputs; every busy state falls back to IDLE when
    // start_calc is withdrawn, and STORE suppresses the write in that case.
    always_comb begin
        next_state          = state;
        mac_clear           = 1'b0;
        mem_read            = 1'b0;
        pixel_read_address  = '0;
        weight_read_address = '0;
        result_write        = 1'b0;
        result_address      = '0;
        busy                = 1'b0;
        done_calc           = 1'b0;
        case (state)
            IDLE: begin
                if (start_calc) begin
                    next_state = CLEAR;
                end
            end
            CLEAR: begin
                busy      = 1'b1;
                mac_clear = 1'b1;
                next_state = start_calc ? FETCH : IDLE;
            end
            FETCH: begin
                busy                = 1'b1;
                mem_read            = 1'b1;
                pixel_read_address  = in_cnt;
                weight_read_address = weight_cnt;
                if (!start_calc) begin
                    next_state = IDLE;
                end else if (in_last) begin
                    next_state = DRAIN;
                end
            end
            DRAIN: begin
                busy = 1'b1;
                if (!start_calc) begin
                    next_state = IDLE;
                end else if (drain_last) begin
                    next_state = STORE;
                end
            end
            STORE: begin
                busy = 1'b1;
                if (!start_calc) begin
                    next_state = IDLE;
                end else begin
                    result_write   = 1'b1;
                    result_address = out_cnt;
                    next_state     = (out_cnt == OUT_LAST) ? DONE : CLEAR;
                end
            end
            DONE: begin
                done_calc = 1'b1;
                if (!start_calc) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // The drain count can never pass its terminal value while draining.
    always_comb begin
        if (state == DRAIN) begin
            assert (drain_cnt <= DRAIN_LAST);
        end
    end

endmodule

// File: tb/tb_calc_sequencer.sv
// Directed bench for calc_sequencer: a small instance (4 inputs, 2 outputs,
// 2 drain cycles) for cycle-exact checks, plus a default-sized instance for
// the full-run addressing and latency figures.
module tb_calc_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_compared   = 0;
    int n_mismatched = 0;

    // Small instance
    logic        n_rst;
    logic        start_calc;
    logic [10:0] pixel_read_address;
    logic [12:0] weight_read_address;
    logic        mem_read;
    logic        mac_clear;
    logic        mac_enable;
    logic        result_write;
    logic [3:0]  result_address;
    logic        busy;
    logic        done_calc;

    // Default-sized instance
    logic        f_n_rst;
    logic        f_start_calc;
    logic [10:0] f_pixel_read_address;
    logic [12:0] f_weight_read_address;
    logic        f_mem_read;
    logic        f_mac_clear;
    logic        f_mac_enable;
    logic        f_result_write;
    logic [3:0]  f_result_address;
    logic        f_busy;
    logic        f_done_calc;

    calc_sequencer #(
        .NUM_INPUTS  (4),
        .NUM_OUTPUTS (2),
        .DRAIN_CYCLES(2)
    ) dut (
        .clk                (clk),
        .n_rst              (n_rst),
        .start_calc         (start_calc),
        .pixel_read_address (pixel_read_address),
        .weight_read_address(weight_read_address),
        .mem_read           (mem_read),
        .mac_clear          (mac_clear),
        .mac_enable         (mac_enable),
        .result_write       (result_write),
        .result_address     (result_address),
        .busy               (busy),
        .done_calc          (done_calc)
    );

    calc_sequencer dut_full (
        .clk                (clk),
        .n_rst              (f_n_rst),
        .start_calc         (f_start_calc),
        .pixel_read_address (f_pixel_read_address),
        .weight_read_address(f_weight_read_address),
        .mem_read           (f_mem_read),
        .mac_clear          (f_mac_clear),
        .mac_enable         (f_mac_enable),
        .result_write       (f_result_write),
        .result_address     (f_result_address),
        .busy               (f_busy),
        .done_calc          (f_done_calc)
    );

    function automatic logic [33:0] all_outputs();
        return {pixel_read_address, weight_read_address, mem_read, mac_clear,
                mac_enable, result_write, result_address, busy, done_calc};
    endfunction

    // Reset both instances, then confirm nothing starts without start_calc.
    task automatic test_reset();
        logic [33:0] zero_outputs;
        zero_outputs = '0;
        n_rst = 1'b0; start_calc = 1'b0;
        f_n_rst = 1'b0; f_start_calc = 1'b0;
        repeat (3) @(negedge clk);
        n_compared++;
        if (all_outputs() !== zero_outputs) begin
            n_mismatched++;
            $display("[TB] FAIL reset_outputs: got %h expected %h", all_outputs(), zero_outputs);
        end
        n_rst = 1'b1;
        f_n_rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            n_compared++;
            if ({busy, mem_read, mac_clear} !== 3'b000) begin
                n_mismatched++;
                $display("[TB] FAIL idle_no_start: got busy/mem_read/mac_clear %b expected 000",
                         {busy, mem_read, mac_clear});
            end
        end
    endtask

    // One complete small run from IDLE, checked cycle by cycle against the
    // hand-derived schedule; leaves start_calc high in DONE.
    task automatic test_single_run(input string tag);
        logic        fetch;
        logic [5:0]  exp_ctrl;
        logic [5:0]  got_ctrl;
        logic [10:0] exp_pixel;
        logic [12:0] exp_weight;
        logic [3:0]  exp_raddr;
        start_calc = 1'b1;
        for (int c = 1; c <= 17; c++) begin
            @(negedge clk);
            fetch      = (c >= 2 && c <= 5) || (c >= 10 && c <= 13);
            exp_pixel  = fetch ? 11'((c <= 5) ? c - 2 : c - 10) : 11'd0;
            exp_weight = fetch ? 13'((c <= 5) ? c - 2 : c - 10 + 4) : 13'd0;
            exp_raddr  = (c == 16) ? 4'd1 : 4'd0;
            exp_ctrl   = {(c == 1 || c == 9), fetch,
                          ((c >= 3 && c <= 6) || (c >= 11 && c <= 14)),
                          (c == 8 || c == 16), (c <= 16), (c >= 17)};
            got_ctrl   = {mac_clear, mem_read, mac_enable, result_write, busy, done_calc};
            n_compared++;
            if (got_ctrl !== exp_ctrl) begin
                n_mismatched++;
                $display("[TB] FAIL %s_ctrl cycle %0d: got clr/rd/en/wr/busy/done %b expected %b",
                         tag, c, got_ctrl, exp_ctrl);
            end
            n_compared++;
            if (pixel_read_address !== exp_pixel) begin
                n_mismatched++;
                $display("[TB] FAIL %s_pixel cycle %0d: got %0d expected %0d",
                         tag, c, pixel_read_address, exp_pixel);
            end
            n_compared++;
            if (weight_read_address !== exp_weight) begin
                n_mismatched++;
                $display("[TB] FAIL %s_weight cycle %0d: got %0d expected %0d",
                         tag, c, weight_read_address, exp_weight);
            end
            n_compared++;
            if (result_address !== exp_raddr) begin
                n_mismatched++;
                $display("[TB] FAIL %s_result_addr cycle %0d: got %0d expected %0d",
                         tag, c, result_address, exp_raddr);
            end
        end
    endtask

    // Holding start_calc in DONE must not retrigger; dropping it returns to IDLE.
    task automatic test_done_hold();
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            n_compared++;
            if ({done_calc, mem_read, busy} !== 3'b100) begin
                n_mismatched++;
                $display("[TB] FAIL done_hold cycle %0d: got done/mem_read/busy %b expected 100",
                         c, {done_calc, mem_read, busy});
            end
        end
        start_calc = 1'b0;
        @(negedge clk);
        n_compared++;
        if ({done_calc, busy} !== 2'b00) begin
            n_mismatched++;
            $display("[TB] FAIL done_release: got done/busy %b expected 00", {done_calc, busy});
        end
    endtask

    // Drop start_calc during FETCH (cycle 4) and confirm a clean abort.
    task automatic test_abort();
        start_calc = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            n_compared++;
            if ({result_write, done_calc} !== 2'b00) begin
                n_mismatched++;
                $display("[TB] FAIL abort_no_write cycle %0d: got wr/done %b expected 00",
                         c, {result_write, done_calc});
            end
            if (c == 4) begin
                n_compared++;
                if ({mem_read, mac_enable} !== 2'b11) begin
                    n_mismatched++;
                    $display("[TB] FAIL abort_pre cycle 4: got rd/en %b expected 11",
                             {mem_read, mac_enable});
                end
                start_calc = 1'b0;
            end
            if (c >= 5) begin
                n_compared++;
                if ({busy, mem_read, mac_enable} !== 3'b000) begin
                    n_mismatched++;
                    $display("[TB] FAIL abort_idle cycle %0d: got busy/rd/en %b expected 000",
                             c, {busy, mem_read, mac_enable});
                end
            end
        end
    endtask

    // A new run straight after an abort must start from neuron 0, weight 0.
    task automatic test_back_to_back();
        test_single_run("after_abort");
        start_calc = 1'b0;
        @(negedge clk);
    endtask

    // Asynchronous reset in cycle 12, then a restart from weight address 0.
    task automatic test_reset_mid_run();
        logic [33:0] zero_outputs;
        zero_outputs = '0;
        start_calc = 1'b1;
        repeat (12) @(negedge clk);
        n_compared++;
        if (weight_read_address !== 13'd6) begin
            n_mismatched++;
            $display("[TB] FAIL pre_reset_weight: got %0d expected 6", weight_read_address);
        end
        n_rst = 1'b0;
        #1;
        n_compared++;
        if (all_outputs() !== zero_outputs) begin
            n_mismatched++;
            $display("[TB] FAIL async_reset_outputs: got %h expected %h", all_outputs(), zero_outputs);
        end
        @(negedge clk);
        n_rst = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            if (c == 1) begin
                n_compared++;
                if (mac_clear !== 1'b1) begin
                    n_mismatched++;
                    $display("[TB] FAIL restart_clear: got %b expected 1", mac_clear);
                end
            end else begin
                n_compared++;
                if ({mem_read, weight_read_address} !== {1'b1, 13'(c - 2)}) begin
                    n_mismatched++;
                    $display("[TB] FAIL restart_weight cycle %0d: got rd=%b addr=%0d expected rd=1 addr=%0d",
                             c, mem_read, weight_read_address, c - 2);
                end
            end
        end
        start_calc = 1'b0;
        @(negedge clk);
    endtask

    // Default-sized full run: result pulses, last weight address, done latency.
    task automatic test_full_run();
        int pulses;
        int first_done;
        int last_weight;
        pulses      = 0;
        first_done  = -1;
        last_weight = -1;
        f_start_calc = 1'b1;
        for (int c = 1; c <= 9000; c++) begin
            @(negedge clk);
            if (f_result_write) begin
                n_compared++;
                if (f_result_address !== 4'(pulses)) begin
                    n_mismatched++;
                    $display("[TB] FAIL full_result_addr pulse %0d: got %0d expected %0d",
                             pulses, f_result_address, pulses);
                end
                pulses++;
            end
            if (f_mem_read) begin
                last_weight = int'(f_weight_read_address);
            end
            if (f_done_calc) begin
                first_done = c;
                break;
            end
        end
        n_compared++;
        if (first_done != 7881) begin
            n_mismatched++;
            $display("[TB] FAIL full_done_cycle: got %0d expected 7881 (-1 = timeout)", first_done);
        end
        n_compared++;
        if (pulses != 10) begin
            n_mismatched++;
            $display("[TB] FAIL full_write_count: got %0d expected 10", pulses);
        end
        n_compared++;
        if (last_weight != 7839) begin
            n_mismatched++;
            $display("[TB] FAIL full_last_weight: got %0d expected 7839", last_weight);
        end
        f_start_calc = 1'b0;
        @(negedge clk);
    endtask

    // Hard stop in case something stalls the sequence of tests.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Test sequence.
    initial begin
        test_reset();
        test_single_run("run");
        test_done_hold();
        test_abort();
        test_back_to_back();
        test_reset_mid_run();
        test_full_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
